// File: rtl/ring_osc_emul_if.sv
// Trim/clock bundle shared between the ring oscillator emulation and its user.
// The slave side is the oscillator; the master side owns the trim word.
interface ring_osc_emul_if #(
  parameter int TRIM_W = 26
);
  logic [TRIM_W-1:0] trim;
  logic [1:0]        clockp;
  logic [5:0]        bcount;

  modport master (output trim, input clockp, input bcount);
  modport slave  (input trim, output clockp, output bcount);
endinterface

// File: rtl/ring_osc_emul.sv
// Clocked emulation of the 13-stage trimmable ring oscillator.
// An internal hiclock toggles every half_q clk cycles, where half_q is
// BASE_HALF plus the number of set trim bits, sampled at each toggle.
// clockp[0] flips on hiclock rising and clockp[1] on hiclock falling, giving
// two outputs of period 4*half_q in quadrature.
module ring_osc_emul #(
  parameter int BASE_HALF = 4,
  parameter int TRIM_W    = 26
) (
  input  logic            clk,
  input  logic            resetn,
  ring_osc_emul_if.slave  osc
);

  localparam int CNT_W = $clog2(BASE_HALF + TRIM_W + 1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_half_q;
  logic             r_hiclock;
  logic [1:0]       r_clockp;

  logic [5:0]       w_bcount;
  logic [CNT_W-1:0] w_half_next;
  logic             w_toggle;

  // Popcount of the trim word; bit position carries no weight.
  always_comb begin
    w_bcount = '0;
    for (int k = 0; k < TRIM_W; k++) begin
      w_bcount = w_bcount + 6'(osc.trim[k]);
    end
  end

  // Length of the next half-period and detection of the toggle edge.
  // The >= comparison keeps the counter from running past half_q-1 even if
  // it were ever left in an out-of-range state.
  always_comb begin
    w_half_next = CNT_W'(BASE_HALF) + CNT_W'(w_bcount);
    w_toggle    = (r_cnt >= (r_half_q - CNT_W'(1)));
  end

  // Half-period counter, hiclock and quadrature outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt     <= '0;
      r_half_q  <= CNT_W'(BASE_HALF);
      r_hiclock <= 1'b0;
      r_clockp  <= 2'b00;
    end else if (w_toggle) begin
      r_cnt     <= '0;
      r_half_q  <= w_half_next;
      r_hiclock <= ~r_hiclock;
      if (!r_hiclock) begin
        r_clockp[0] <= ~r_clockp[0];
      end else begin
        r_clockp[1] <= ~r_clockp[1];
      end
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign osc.clockp = r_clockp;
  assign osc.bcount = w_bcount;

endmodule

// File: tb/tb_ring_osc_emul.sv
// Directed bench for ring_osc_emul with BASE_HALF=4, TRIM_W=26.
// Edge 1 is the first rising clk edge after resetn is released; outputs are
// sampled 1 time unit after each rising edge.
module tb_ring_osc_emul;

  logic clk = 1'b0;
  logic resetn = 1'b0;

  ring_osc_emul_if #(.TRIM_W(26)) osc_if ();

  ring_osc_emul #(.BASE_HALF(4), .TRIM_W(26)) dut (
    .clk    (clk),
    .resetn (resetn),
    .osc    (osc_if.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int edge_n   = 0;

  int         cap_edge[$];
  logic [1:0] cap_val[$];

  // Advance one rising edge and settle.
  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  // Hold reset with the given trim, then release between edges.
  task automatic do_reset(input logic [25:0] t);
    resetn = 1'b0;
    osc_if.trim = t;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    edge_n = 0;
  endtask

  // Run n edges, recording every clockp change; optionally load new trim
  // right after edge chg_edge.
  task automatic capture(input int n, input int chg_edge, input logic [25:0] chg_trim);
    logic [1:0] prev;
    cap_edge.delete();
    cap_val.delete();
    prev = osc_if.clockp;
    for (int e = 0; e < n; e++) begin
      step();
      if (osc_if.clockp !== prev) begin
        cap_edge.push_back(edge_n);
        cap_val.push_back(osc_if.clockp);
        prev = osc_if.clockp;
      end
      if (edge_n == chg_edge) osc_if.trim = chg_trim;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    osc_if.trim = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (osc_if.clockp !== 2'b00) begin
      n_errors++;
      $display("FAIL reset_clockp: got %b expected 00", osc_if.clockp);
    end
    n_checks++;
    if (osc_if.bcount !== 6'd0) begin
      n_errors++;
      $display("FAIL reset_bcount: got %0d expected 0", osc_if.bcount);
    end
    $display("test_reset: clockp=%b bcount=%0d", osc_if.clockp, osc_if.bcount);
  endtask

  task automatic test_startup();
    logic [1:0] exp_cp;
    int m;
    do_reset('0);
    for (int e = 1; e <= 20; e++) begin
      step();
      m = e % 16;
      exp_cp[0] = (m >= 4) && (m < 12);
      exp_cp[1] = (m >= 8);
      n_checks++;
      if (osc_if.clockp !== exp_cp) begin
        n_errors++;
        $display("FAIL startup_edge%0d: got %b expected %b", e, osc_if.clockp, exp_cp);
      end
    end
    $display("test_startup: 20 edges sampled, trim=0");
  endtask

  task automatic test_max_trim();
    int         exp_e[5] = '{4, 34, 64, 94, 124};
    logic [1:0] exp_v[5] = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01};
    do_reset(26'h3FFFFFF);
    n_checks++;
    if (osc_if.bcount !== 6'd26) begin
      n_errors++;
      $display("FAIL max_bcount: got %0d expected 26", osc_if.bcount);
    end
    capture(130, 0, '0);
    n_checks++;
    if (cap_edge.size() != 5) begin
      n_errors++;
      $display("FAIL max_nchanges: got %0d expected 5", cap_edge.size());
    end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (i >= cap_edge.size() || cap_edge[i] != exp_e[i] || cap_val[i] !== exp_v[i]) begin
        n_errors++;
        if (i < cap_edge.size())
          $display("FAIL max_change%0d: got edge %0d val %b expected edge %0d val %b",
                   i, cap_edge[i], cap_val[i], exp_e[i], exp_v[i]);
        else
          $display("FAIL max_change%0d: got none expected edge %0d val %b", i, exp_e[i], exp_v[i]);
      end
    end
    $display("test_max_trim: %0d changes captured", cap_edge.size());
  endtask

  task automatic test_nonweighted(input logic [25:0] t);
    int         exp_e[5] = '{4, 10, 16, 22, 28};
    logic [1:0] exp_v[5] = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01};
    do_reset(t);
    n_checks++;
    if (osc_if.bcount !== 6'd2) begin
      n_errors++;
      $display("FAIL nw_bcount_%h: got %0d expected 2", t, osc_if.bcount);
    end
    capture(30, 0, '0);
    n_checks++;
    if (cap_edge.size() != 5) begin
      n_errors++;
      $display("FAIL nw_nchanges_%h: got %0d expected 5", t, cap_edge.size());
    end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (i >= cap_edge.size() || cap_edge[i] != exp_e[i] || cap_val[i] !== exp_v[i]) begin
        n_errors++;
        $display("FAIL nw_change%0d_%h: expected edge %0d val %b", i, t, exp_e[i], exp_v[i]);
      end
    end
    $display("test_nonweighted: trim=%h changes=%0d", t, cap_edge.size());
  endtask

  task automatic test_mid_trim_change();
    int         exp_e[4] = '{4, 8, 38, 68};
    logic [1:0] exp_v[4] = '{2'b01, 2'b11, 2'b10, 2'b00};
    do_reset('0);
    capture(70, 6, 26'h3FFFFFF);
    n_checks++;
    if (cap_edge.size() != 4) begin
      n_errors++;
      $display("FAIL midtrim_nchanges: got %0d expected 4", cap_edge.size());
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (i >= cap_edge.size() || cap_edge[i] != exp_e[i] || cap_val[i] !== exp_v[i]) begin
        n_errors++;
        $display("FAIL midtrim_change%0d: expected edge %0d val %b", i, exp_e[i], exp_v[i]);
      end
    end
    $display("test_mid_trim_change: changes=%0d", cap_edge.size());
  endtask

  task automatic test_reset_mid();
    do_reset('0);
    repeat (9) step();
    n_checks++;
    if (osc_if.clockp !== 2'b11) begin
      n_errors++;
      $display("FAIL rstmid_pre: got %b expected 11", osc_if.clockp);
    end
    #2;
    resetn = 1'b0;
    #1;
    n_checks++;
    if (osc_if.clockp !== 2'b00) begin
      n_errors++;
      $display("FAIL rstmid_async: got %b expected 00", osc_if.clockp);
    end
    osc_if.trim = 26'h3FFFFFF;
    @(negedge clk);
    resetn = 1'b1;
    edge_n = 0;
    capture(40, 0, '0);
    n_checks++;
    if (cap_edge.size() != 2 || cap_edge[0] != 4 || cap_val[0] !== 2'b01 ||
        cap_edge[1] != 34 || cap_val[1] !== 2'b11) begin
      n_errors++;
      $display("FAIL rstmid_restart: got %0d changes (first edge %0d) expected edges 4,34",
               cap_edge.size(), (cap_edge.size() > 0) ? cap_edge[0] : -1);
    end
    $display("test_reset_mid: restart changes=%0d", cap_edge.size());
  endtask

  task automatic test_bcount();
    logic [25:0] vec[5] = '{26'h0000000, 26'h3FFFFFF, 26'h2AAAAAA, 26'h1555555, 26'h00000FF};
    logic [5:0]  exp[5] = '{6'd0, 6'd26, 6'd13, 6'd13, 6'd8};
    logic [25:0] r;
    for (int pass = 0; pass < 2; pass++) begin
      resetn = (pass == 1);
      for (int i = 0; i < 26; i++) begin
        osc_if.trim = 26'd1 << i;
        #1;
        n_checks++;
        if (osc_if.bcount !== 6'd1) begin
          n_errors++;
          $display("FAIL bcount_walk%0d_rst%0d: got %0d expected 1", i, pass, osc_if.bcount);
        end
      end
      for (int i = 0; i < 5; i++) begin
        osc_if.trim = vec[i];
        #1;
        n_checks++;
        if (osc_if.bcount !== exp[i]) begin
          n_errors++;
          $display("FAIL bcount_vec%0d_rst%0d: got %0d expected %0d", i, pass, osc_if.bcount, exp[i]);
        end
      end
      for (int i = 0; i < 8; i++) begin
        r = 26'($urandom);
        osc_if.trim = r;
        #1;
        n_checks++;
        if (osc_if.bcount !== 6'($countones(r))) begin
          n_errors++;
          $display("FAIL bcount_rand_%h: got %0d expected %0d", r, osc_if.bcount, $countones(r));
        end
      end
    end
    $display("test_bcount: walking-ones, fixed and random vectors done");
  endtask

  initial begin
    osc_if.trim = '0;
    test_reset();
    test_startup();
    test_max_trim();
    test_nonweighted(26'h2000001);
    test_nonweighted(26'h0000003);
    test_mid_trim_change();
    test_reset_mid();
    test_bcount();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
